// File: rtl/pc_next_ctrl_if.sv
// pc_next_ctrl_if
// Bundles the fetch-stage next-PC control signals.
//   pc_in            current PC from the PC register output
//   stall            hazard stall, PC must not advance while high
//   redirect_valid   branch taken / jump resolved this cycle
//   redirect_target  destination for redirect_valid
//   halt_fetch       HLT decoded for the instruction at pc_in
//   next_pc          value to load into the PC register
//   pc_en            PC register write enable
//   halted           high while fetch is frozen by a halt
//   redirect_pending high while a stalled redirect is held
// master: pipeline side (drives pc_in/stall/redirect/halt).
// slave : the next-PC controller.
interface pc_next_ctrl_if #(
   parameter int unsigned PC_WIDTH = 16
);
   logic [PC_WIDTH-1:0] pc_in;
   logic                stall;
   logic                redirect_valid;
   logic [PC_WIDTH-1:0] redirect_target;
   logic                halt_fetch;
   logic [PC_WIDTH-1:0] next_pc;
   logic                pc_en;
   logic                halted;
   logic                redirect_pending;

   modport master (
      output pc_in, stall, redirect_valid, redirect_target, halt_fetch,
      input  next_pc, pc_en, halted, redirect_pending
   );

   modport slave (
      input  pc_in, stall, redirect_valid, redirect_target, halt_fetch,
      output next_pc, pc_en, halted, redirect_pending
   );
endinterface

// File: rtl/pc_next_ctrl.sv
// pc_next_ctrl
// Next-PC generator for the fetch-stage PC register. Chooses sequential
// increment, redirect, or hold each cycle; remembers a redirect that lands
// during a stall and freezes fetch after a decoded halt.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  pc_next_ctrl_if.slave (see interface for signal list)
module pc_next_ctrl #(
   parameter int unsigned         PC_WIDTH     = 16,
   parameter int unsigned         PC_INC       = 2,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic               clk,
   input  logic               rst,
   pc_next_ctrl_if.slave      bus
);

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HOLD = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [PC_WIDTH-1:0] pend_q, pend_d;
   logic [PC_WIDTH-1:0] next_pc_c;
   logic                pc_en_c;
   logic [PC_WIDTH-1:0] pc_seq;

   // Carry out of the increment is dropped so the PC wraps.
   assign pc_seq = bus.pc_in + PC_WIDTH'(PC_INC);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      next_pc_c = bus.pc_in;
      pc_en_c   = 1'b0;

      unique case (state_q)
         RUN: begin
            if (bus.redirect_valid && !bus.stall) begin
               next_pc_c = bus.redirect_target;
               pc_en_c   = 1'b1;
            end else if (bus.redirect_valid) begin
               pend_d  = bus.redirect_target;
               state_d = HOLD;
            end else if (bus.halt_fetch) begin
               state_d = HALT;
            end else if (!bus.stall) begin
               next_pc_c = pc_seq;
               pc_en_c   = 1'b1;
            end
         end

         // halt_fetch is ignored here: the instruction at pc_in is squashed.
         HOLD: begin
            if (bus.stall) begin
               if (bus.redirect_valid) pend_d = bus.redirect_target;
            end else begin
               next_pc_c = bus.redirect_valid ? bus.redirect_target : pend_q;
               pc_en_c   = 1'b1;
               state_d   = RUN;
            end
         end

         HALT: begin
            if (bus.redirect_valid && !bus.stall) begin
               next_pc_c = bus.redirect_target;
               pc_en_c   = 1'b1;
               state_d   = RUN;
            end else if (bus.redirect_valid) begin
               pend_d  = bus.redirect_target;
               state_d = HOLD;
            end
         end

         default: state_d = RUN;
      endcase

      // Reset overrides every output combinationally.
      if (rst) begin
         next_pc_c = RESET_VECTOR;
         pc_en_c   = 1'b0;
      end
   end

   assign bus.next_pc          = next_pc_c;
   assign bus.pc_en            = pc_en_c;
   assign bus.halted           = !rst && (state_q == HALT);
   assign bus.redirect_pending = !rst && (state_q == HOLD);

endmodule

// File: tb/tb_pc_next_ctrl.sv
// tb_pc_next_ctrl
// Directed bench for pc_next_ctrl. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
module tb_pc_next_ctrl;

   logic clk;
   logic rst;
   int   passes;
   int   total;

   pc_next_ctrl_if #(.PC_WIDTH(16)) bus ();

   pc_next_ctrl #(
      .PC_WIDTH    (16),
      .PC_INC      (2),
      .RESET_VECTOR(16'h0000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [15:0] pc, input logic st, input logic rv,
                        input logic [15:0] tgt, input logic hf);
      bus.pc_in           = pc;
      bus.stall           = st;
      bus.redirect_valid  = rv;
      bus.redirect_target = tgt;
      bus.halt_fetch      = hf;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(16'h1234, 1'b0, 1'b1, 16'h5555, 1'b0);
      total++; if (bus.next_pc !== 16'h0000) $display("FAIL rst_next_pc got %h exp 0000", bus.next_pc); else passes++;
      total++; if (bus.pc_en !== 1'b0) $display("FAIL rst_pc_en got %b exp 0", bus.pc_en); else passes++;
      total++; if (bus.halted !== 1'b0) $display("FAIL rst_halted got %b exp 0", bus.halted); else passes++;
      total++; if (bus.redirect_pending !== 1'b0) $display("FAIL rst_pending got %b exp 0", bus.redirect_pending); else passes++;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_free_run();
      logic [15:0] pc;
      pc = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         drive(pc, 1'b0, 1'b0, 16'h0000, 1'b0);
         total++; if (bus.next_pc !== pc + 16'd2) $display("FAIL free_run_next_pc[%0d] got %h exp %h", i, bus.next_pc, pc + 16'd2); else passes++;
         total++; if (bus.pc_en !== 1'b1) $display("FAIL free_run_pc_en[%0d] got %b exp 1", i, bus.pc_en); else passes++;
         pc = pc + 16'd2;
         tick();
      end
   endtask

   task automatic test_wrap();
      drive(16'hFFFE, 1'b0, 1'b0, 16'h0000, 1'b0);
      total++; if (bus.next_pc !== 16'h0000) $display("FAIL wrap_next_pc got %h exp 0000", bus.next_pc); else passes++;
      total++; if (bus.pc_en !== 1'b1) $display("FAIL wrap_pc_en got %b exp 1", bus.pc_en); else passes++;
      tick();
      // stall alone holds the PC
      drive(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
      total++; if (bus.pc_en !== 1'b0) $display("FAIL stall_pc_en got %b exp 0", bus.pc_en); else passes++;
      total++; if (bus.next_pc !== 16'h0000) $display("FAIL stall_next_pc got %h exp 0000", bus.next_pc); else passes++;
      tick();
   endtask

   task automatic test_stalled_redirect();
      drive(16'h0010, 1'b1, 1'b1, 16'h0040, 1'b0);
      total++; if (bus.pc_en !== 1'b0) $display("FAIL sr_c1_pc_en got %b exp 0", bus.pc_en); else passes++;
      total++; if (bus.next_pc !== 16'h0010) $display("FAIL sr_c1_next_pc got %h exp 0010", bus.next_pc); else passes++;
      total++; if (bus.redirect_pending !== 1'b0) $display("FAIL sr_c1_pending got %b exp 0", bus.redirect_pending); else passes++;
      tick();
      for (int i = 2; i <= 3; i++) begin
         drive(16'h0010, 1'b1, 1'b0, 16'h0000, 1'b0);
         total++; if (bus.pc_en !== 1'b0) $display("FAIL sr_c%0d_pc_en got %b exp 0", i, bus.pc_en); else passes++;
         total++; if (bus.redirect_pending !== 1'b1) $display("FAIL sr_c%0d_pending got %b exp 1", i, bus.redirect_pending); else passes++;
         tick();
      end
      // stall drops; halt_fetch must be ignored while holding
      drive(16'h0010, 1'b0, 1'b0, 16'h0000, 1'b1);
      total++; if (bus.next_pc !== 16'h0040) $display("FAIL sr_release_next_pc got %h exp 0040", bus.next_pc); else passes++;
      total++; if (bus.pc_en !== 1'b1) $display("FAIL sr_release_pc_en got %b exp 1", bus.pc_en); else passes++;
      tick();
      drive(16'h0040, 1'b0, 1'b0, 16'h0000, 1'b0);
      total++; if (bus.redirect_pending !== 1'b0) $display("FAIL sr_after_pending got %b exp 0", bus.redirect_pending); else passes++;
      total++; if (bus.halted !== 1'b0) $display("FAIL sr_after_halted got %b exp 0", bus.halted); else passes++;
      total++; if (bus.next_pc !== 16'h0042) $display("FAIL sr_after_next_pc got %h exp 0042", bus.next_pc); else passes++;
      tick();
      // latest redirect wins
      drive(16'h0042, 1'b1, 1'b1, 16'h0040, 1'b0);
      tick();
      drive(16'h0042, 1'b1, 1'b1, 16'h0080, 1'b0);
      total++; if (bus.pc_en !== 1'b0) $display("FAIL lw_stall_pc_en got %b exp 0", bus.pc_en); else passes++;
      tick();
      drive(16'h0042, 1'b0, 1'b0, 16'h0000, 1'b0);
      total++; if (bus.next_pc !== 16'h0080) $display("FAIL lw_next_pc got %h exp 0080", bus.next_pc); else passes++;
      total++; if (bus.pc_en !== 1'b1) $display("FAIL lw_pc_en got %b exp 1", bus.pc_en); else passes++;
      tick();
   endtask

   task automatic test_halt();
      // halt with stall high still enters HALT
      drive(16'h0010, 1'b1, 1'b0, 16'h0000, 1'b1);
      total++; if (bus.pc_en !== 1'b0) $display("FAIL halt_c0_pc_en got %b exp 0", bus.pc_en); else passes++;
      total++; if (bus.halted !== 1'b0) $display("FAIL halt_c0_halted got %b exp 0", bus.halted); else passes++;
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(16'h0010, (i == 1), 1'b0, 16'h0000, 1'b0);
         total++; if (bus.halted !== 1'b1) $display("FAIL halt_hold%0d_halted got %b exp 1", i, bus.halted); else passes++;
         total++; if (bus.pc_en !== 1'b0) $display("FAIL halt_hold%0d_pc_en got %b exp 0", i, bus.pc_en); else passes++;
         total++; if (bus.next_pc !== 16'h0010) $display("FAIL halt_hold%0d_next_pc got %h exp 0010", i, bus.next_pc); else passes++;
         tick();
      end
      drive(16'h0010, 1'b0, 1'b1, 16'h0020, 1'b0);
      total++; if (bus.next_pc !== 16'h0020) $display("FAIL halt_exit_next_pc got %h exp 0020", bus.next_pc); else passes++;
      total++; if (bus.pc_en !== 1'b1) $display("FAIL halt_exit_pc_en got %b exp 1", bus.pc_en); else passes++;
      tick();
      drive(16'h0020, 1'b0, 1'b0, 16'h0000, 1'b0);
      total++; if (bus.halted !== 1'b0) $display("FAIL halt_after_halted got %b exp 0", bus.halted); else passes++;
      total++; if (bus.next_pc !== 16'h0022) $display("FAIL halt_after_next_pc got %h exp 0022", bus.next_pc); else passes++;
      tick();
      // HALT + stalled redirect goes to HOLD
      drive(16'h0022, 1'b0, 1'b0, 16'h0000, 1'b1);
      tick();
      drive(16'h0022, 1'b1, 1'b1, 16'h0300, 1'b0);
      total++; if (bus.pc_en !== 1'b0) $display("FAIL halt_hold_pc_en got %b exp 0", bus.pc_en); else passes++;
      tick();
      drive(16'h0022, 1'b0, 1'b0, 16'h0000, 1'b0);
      total++; if (bus.halted !== 1'b0) $display("FAIL halt_hold_halted got %b exp 0", bus.halted); else passes++;
      total++; if (bus.redirect_pending !== 1'b1) $display("FAIL halt_hold_pending got %b exp 1", bus.redirect_pending); else passes++;
      total++; if (bus.next_pc !== 16'h0300) $display("FAIL halt_hold_next_pc got %h exp 0300", bus.next_pc); else passes++;
      tick();
   endtask

   task automatic test_halt_and_redirect();
      drive(16'h0030, 1'b0, 1'b1, 16'h0100, 1'b1);
      total++; if (bus.next_pc !== 16'h0100) $display("FAIL hr_next_pc got %h exp 0100", bus.next_pc); else passes++;
      total++; if (bus.pc_en !== 1'b1) $display("FAIL hr_pc_en got %b exp 1", bus.pc_en); else passes++;
      tick();
      drive(16'h0100, 1'b0, 1'b0, 16'h0000, 1'b0);
      total++; if (bus.halted !== 1'b0) $display("FAIL hr_halted got %b exp 0", bus.halted); else passes++;
      total++; if (bus.next_pc !== 16'h0102) $display("FAIL hr_after_next_pc got %h exp 0102", bus.next_pc); else passes++;
      tick();
   endtask

   task automatic test_reset_in_hold();
      drive(16'h0050, 1'b1, 1'b1, 16'h0200, 1'b0);
      tick();
      drive(16'h0050, 1'b1, 1'b0, 16'h0000, 1'b0);
      total++; if (bus.redirect_pending !== 1'b1) $display("FAIL rh_pending_before got %b exp 1", bus.redirect_pending); else passes++;
      rst = 1'b1;
      #1;
      total++; if (bus.next_pc !== 16'h0000) $display("FAIL rh_rst_next_pc got %h exp 0000", bus.next_pc); else passes++;
      total++; if (bus.pc_en !== 1'b0) $display("FAIL rh_rst_pc_en got %b exp 0", bus.pc_en); else passes++;
      total++; if (bus.redirect_pending !== 1'b0) $display("FAIL rh_rst_pending got %b exp 0", bus.redirect_pending); else passes++;
      tick();
      rst = 1'b0;
      drive(16'h0050, 1'b0, 1'b0, 16'h0000, 1'b0);
      total++; if (bus.next_pc !== 16'h0052) $display("FAIL rh_after_next_pc got %h exp 0052", bus.next_pc); else passes++;
      total++; if (bus.pc_en !== 1'b1) $display("FAIL rh_after_pc_en got %b exp 1", bus.pc_en); else passes++;
      total++; if (bus.redirect_pending !== 1'b0) $display("FAIL rh_after_pending got %b exp 0", bus.redirect_pending); else passes++;
      tick();
      drive(16'h0052, 1'b0, 1'b0, 16'h0000, 1'b0);
      total++; if (bus.next_pc !== 16'h0054) $display("FAIL rh_after2_next_pc got %h exp 0054", bus.next_pc); else passes++;
      tick();
   endtask

   initial begin
      passes = 0;
      total  = 0;
      rst    = 1'b1;
      bus.pc_in           = '0;
      bus.stall           = 1'b0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_target = '0;
      bus.halt_fetch      = 1'b0;
      test_reset();
      test_free_run();
      test_wrap();
      test_stalled_redirect();
      test_halt();
      test_halt_and_redirect();
      test_reset_in_hold();
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
